// File: rtl/regex_memory_arbiter.sv
// regex_memory_arbiter
// Shares one synchronous single-port instruction RAM between 2**CPU_ID_BITS
// regex CPUs (served round-robin) and one host program-load write port
// (fixed priority over every CPU). At most one RAM access is granted per cycle.
//
// Handshake: a requester raises valid with a stable address (and data for the
// host) and holds both until it sees its one-cycle registered ready pulse.
// The pulse cycle is also the RAM access cycle; for a CPU read the word
// appears on cpu_memory_data in the following cycle. A requester that is
// currently seeing its ready pulse is not eligible, so it is never granted
// twice for one request.
module regex_memory_arbiter #(
    parameter int CPU_ID_BITS       = 2,
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    localparam int N                = 2 ** CPU_ID_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   cpu_memory_valid,
    input  logic [N*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
    output logic [N-1:0]                   cpu_memory_ready,
    output logic [MEMORY_WIDTH-1:0]        cpu_memory_data,
    input  logic                           host_wr_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0]   host_wr_addr,
    input  logic [MEMORY_WIDTH-1:0]        host_wr_data,
    output logic                           host_wr_ready,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr,
    output logic [MEMORY_WIDTH-1:0]        mem_wdata,
    input  logic [MEMORY_WIDTH-1:0]        mem_rdata
);

    logic [N-1:0]                 ready_q, ready_d;
    logic                         host_ready_q, host_ready_d;
    logic                         en_q, en_d;
    logic                         we_q, we_d;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEMORY_WIDTH-1:0]      wdata_q, wdata_d;
    logic [CPU_ID_BITS-1:0]       rr_ptr_q, rr_ptr_d;

    logic [N-1:0]                 cpu_req;
    logic                         host_req;
    logic                         cpu_hit;
    logic [CPU_ID_BITS-1:0]       cpu_win;
    logic [CPU_ID_BITS-1:0]       scan_idx;

    // Pick the winner for this cycle and build the next registered grant/RAM command.
    always_comb begin
        cpu_req  = cpu_memory_valid & ~ready_q;
        host_req = host_wr_valid & ~host_ready_q;

        // Scan from rr_ptr upward; the pointer width makes the index wrap modulo N.
        cpu_hit  = 1'b0;
        cpu_win  = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = rr_ptr_q + CPU_ID_BITS'(k);
            if (!cpu_hit && cpu_req[scan_idx]) begin
                cpu_hit = 1'b1;
                cpu_win = scan_idx;
            end
        end

        // Address/write data hold when nothing is granted; pulses drop to 0.
        ready_d      = '0;
        host_ready_d = 1'b0;
        en_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rr_ptr_d     = rr_ptr_q;

        if (host_req) begin
            // Host write wins outright and leaves the CPU rotation untouched.
            host_ready_d = 1'b1;
            en_d         = 1'b1;
            we_d         = 1'b1;
            addr_d       = host_wr_addr;
            wdata_d      = host_wr_data;
        end else if (cpu_hit) begin
            ready_d[cpu_win] = 1'b1;
            en_d             = 1'b1;
            addr_d           = cpu_memory_addr[int'(cpu_win)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            rr_ptr_d         = cpu_win + CPU_ID_BITS'(1);
        end
    end

    // Register grants, RAM command and round-robin pointer; reset drops any pending grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= '0;
            host_ready_q <= 1'b0;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rr_ptr_q     <= '0;
        end else begin
            ready_q      <= ready_d;
            host_ready_q <= host_ready_d;
            en_q         <= en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign cpu_memory_ready = ready_q;
    assign host_wr_ready    = host_ready_q;
    assign mem_en           = en_q;
    assign mem_we           = we_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    // The read word is broadcast; only the CPU that just saw ready samples it.
    assign cpu_memory_data  = mem_rdata;

endmodule

// File: tb/tb_regex_memory_arbiter.sv
// tb_regex_memory_arbiter
// Drives the arbiter with directed scenarios and a randomized phase, backed by
// a behavioural RAM. A reference model tracks which requester should own each
// cycle and what word each CPU read must return.
module tb_regex_memory_arbiter;

    localparam int IDB = 2;
    localparam int N   = 4;
    localparam int W   = 20;
    localparam int AW  = 11;

    logic          clk;
    logic          rst;
    logic [N-1:0]  cpu_valid;
    logic [N*AW-1:0] cpu_addr;
    logic [N-1:0]  cpu_ready;
    logic [W-1:0]  cpu_data;
    logic          host_valid;
    logic [AW-1:0] host_addr;
    logic [W-1:0]  host_data;
    logic          host_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    regex_memory_arbiter #(
        .CPU_ID_BITS(IDB),
        .MEMORY_WIDTH(W),
        .MEMORY_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_memory_valid(cpu_valid),
        .cpu_memory_addr(cpu_addr),
        .cpu_memory_ready(cpu_ready),
        .cpu_memory_data(cpu_data),
        .host_wr_valid(host_valid),
        .host_wr_addr(host_addr),
        .host_wr_data(host_data),
        .host_wr_ready(host_ready),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Clock and behavioural single-port RAM with one cycle of read latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ram [2**AW];
    logic [W-1:0] shadow [2**AW];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [AW-1:0] a, input logic [W-1:0] w);
        ram[a]    = w;
        shadow[a] = w;
    endtask

    // Reference model: who owns the next cycle, and what a CPU read returns.
    int           m_ptr = 0;
    logic [N-1:0] m_ready = '0;
    logic         m_hready = 1'b0;
    logic         m_en = 1'b0;
    logic         m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0] m_wdata = '0;
    logic         pend_cpu = 1'b0;
    logic [W-1:0] pend_word = '0;
    logic         chk_data = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         live = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            chk_data = pend_cpu;
            exp_data = pend_word;
            pend_cpu = 1'b0;
            if (rst) begin
                m_ptr = 0; m_ready = '0; m_hready = 1'b0;
                m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            end else begin
                logic [N-1:0] elig;
                logic         h_elig;
                h_elig   = host_valid && !m_hready;
                elig     = cpu_valid & ~m_ready;
                m_ready  = '0;
                m_hready = 1'b0;
                m_en     = 1'b0;
                m_we     = 1'b0;
                if (h_elig) begin
                    m_hready = 1'b1; m_en = 1'b1; m_we = 1'b1;
                    m_addr = host_addr; m_wdata = host_data;
                    shadow[host_addr] = host_data;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (elig[c]) begin
                            m_ready[c] = 1'b1;
                            m_en       = 1'b1;
                            m_addr     = cpu_addr[c*AW +: AW];
                            pend_word  = shadow[m_addr];
                            pend_cpu   = 1'b1;
                            m_ptr      = (c + 1) % N;
                            break;
                        end
                    end
                end
            end
            live = 1'b1;
        end
    end

    // Compare process: every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                check("m_cpu_ready", 32'(cpu_ready), 32'(m_ready));
                check("m_host_ready", 32'(host_ready), 32'(m_hready));
                check("m_mem_en", 32'(mem_en), 32'(m_en));
                check("m_mem_we", 32'(mem_we), 32'(m_we));
                check("m_mem_addr", 32'(mem_addr), 32'(m_addr));
                check("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                if (chk_data) check("m_cpu_data", 32'(cpu_data), 32'(exp_data));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    logic [W-1:0] four_w [4];
    int pulses;

    initial begin
        four_w = '{20'h0A010, 20'h0B020, 20'h0C030, 20'h0D040};
        rst = 1'b1; cpu_valid = '0; cpu_addr = '0;
        host_valid = 1'b0; host_addr = '0; host_data = '0;
        for (int a = 0; a < 2**AW; a++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            ram[a] = w; shadow[a] = w;
        end
        set_word(11'h1A5, 20'h30062);
        for (int i = 0; i < 4; i++) set_word(AW'(16 * (i + 1)), four_w[i]);

        repeat (3) tick();
        check("rst_ready", 32'(cpu_ready), 32'h0);
        check("rst_hready", 32'(host_ready), 32'h0);
        check("rst_en", 32'(mem_en), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;

        // All four CPUs at once from pointer 0: back-to-back grants 0..3.
        for (int i = 0; i < N; i++) cpu_addr[i*AW +: AW] = AW'(16 * (i + 1));
        cpu_valid = '1;
        for (int k = 0; k < N; k++) begin
            tick();
            check("all4_ready", 32'(cpu_ready), 32'(1 << k));
            check("all4_addr", 32'(mem_addr), 32'(16 * (k + 1)));
            if (k > 0) check("all4_data", 32'(cpu_data), 32'(four_w[k-1]));
            cpu_valid[k] = 1'b0;
        end
        tick();
        check("all4_data_last", 32'(cpu_data), 32'(four_w[3]));
        check("all4_idle", 32'(cpu_ready), 32'h0);

        // CPU 2 alone.
        cpu_addr[2*AW +: AW] = 11'h1A5;
        cpu_valid[2] = 1'b1;
        tick();
        check("c2_ready", 32'(cpu_ready), 32'h4);
        check("c2_addr", 32'(mem_addr), 32'h1A5);
        check("c2_en", 32'(mem_en), 32'h1);
        check("c2_we", 32'(mem_we), 32'h0);
        cpu_valid[2] = 1'b0;
        tick();
        check("c2_data", 32'(cpu_data), 32'h30062);

        // Pointer now 3: CPUs 0 and 3 -> 3 first, then 0.
        cpu_addr[0 +: AW] = 11'h100;
        cpu_addr[3*AW +: AW] = 11'h133;
        cpu_valid = 4'b1001;
        tick();
        check("wrap_first", 32'(cpu_ready), 32'h8);
        cpu_valid[3] = 1'b0;
        tick();
        check("wrap_second", 32'(cpu_ready), 32'h1);
        cpu_valid[0] = 1'b0;
        tick();
        // Pointer should be 1: CPUs 0 and 1 -> 1 first.
        cpu_valid = 4'b0011;
        tick();
        check("ptr1_first", 32'(cpu_ready), 32'h2);
        cpu_valid[1] = 1'b0;
        tick();
        check("ptr1_second", 32'(cpu_ready), 32'h1);
        cpu_valid[0] = 1'b0;
        tick();

        // Host write beats CPU 1; CPU 1 then reads the new word.
        host_valid = 1'b1; host_addr = 11'h07F; host_data = 20'h20131;
        cpu_addr[1*AW +: AW] = 11'h07F;
        cpu_valid[1] = 1'b1;
        tick();
        check("host_hready", 32'(host_ready), 32'h1);
        check("host_we", 32'(mem_we), 32'h1);
        check("host_wdata", 32'(mem_wdata), 32'h20131);
        check("host_cpu_wait", 32'(cpu_ready), 32'h0);
        host_valid = 1'b0;
        tick();
        check("host_then_cpu", 32'(cpu_ready), 32'h2);
        check("host_then_we", 32'(mem_we), 32'h0);
        cpu_valid[1] = 1'b0;
        tick();
        check("host_readback", 32'(cpu_data), 32'h20131);

        // Reset in the decision cycle of CPU 0.
        cpu_addr[0 +: AW] = 11'h055;
        cpu_valid[0] = 1'b1;
        rst = 1'b1;
        tick();
        check("rstd_ready", 32'(cpu_ready), 32'h0);
        check("rstd_en", 32'(mem_en), 32'h0);
        check("rstd_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        tick();
        check("rstd_regrant", 32'(cpu_ready), 32'h1);
        check("rstd_regrant_addr", 32'(mem_addr), 32'h055);
        cpu_valid[0] = 1'b0;
        tick();

        // CPU 1 toggling valid: one pulse per request, never adjacent.
        pulses = 0;
        for (int r = 0; r < 20; r++) begin
            cpu_addr[1*AW +: AW] = AW'($urandom_range(0, 2**AW - 1));
            cpu_valid[1] = 1'b1;
            tick();
            if (cpu_ready[1]) pulses++;
            check("alt_pulse", 32'(cpu_ready), 32'h2);
            cpu_valid[1] = 1'b0;
            tick();
            check("alt_gap", 32'(cpu_ready), 32'h0);
        end
        check("alt_count", 32'(pulses), 32'd20);

        // Randomized traffic over a small address window to mix reads and writes.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (cpu_valid[i] && cpu_ready[i]) cpu_valid[i] = 1'b0;
                else if (cpu_valid[i] && $urandom_range(0, 99) < 2) cpu_valid[i] = 1'b0;
                else if (!cpu_valid[i] && $urandom_range(0, 99) < 40) begin
                    cpu_valid[i] = 1'b1;
                    cpu_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                end
            end
            if (host_valid && host_ready) host_valid = 1'b0;
            else if (!host_valid && $urandom_range(0, 99) < 8) begin
                host_valid = 1'b1;
                host_addr  = AW'($urandom_range(0, 31));
                host_data  = W'($urandom);
            end
            tick();
        end

        rst = 1'b0; cpu_valid = '0; host_valid = 1'b0;
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regex_memory_arbiter.md
# regex_memory_arbiter

Shares one synchronous single-port instruction memory between 2**CPU_ID_BITS regex_cpu instances and one host program-load write port. Each regex_cpu sees its usual memory handshake (hold memory_valid/memory_addr, get a one-cycle memory_ready pulse, sample memory_data the following cycle). The arbiter sits between the CPU array and the instruction RAM. It grants at most one access per cycle: the host has fixed priority, and the CPUs are served round-robin.

## Interface
- CPU_ID_BITS, 2, log2 of number of CPUs (N = 2**CPU_ID_BITS)
- MEMORY_WIDTH, 20, instruction word width
- MEMORY_ADDR_WIDTH, 11, instruction memory address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_memory_valid  in  N  per-CPU fetch request, held until its ready pulse
- cpu_memory_addr  in  N*MEMORY_ADDR_WIDTH  per-CPU fetch address, packed, CPU i at [i*AW +: AW]
- cpu_memory_ready  out  N  registered one-hot grant pulse, one cycle wide
- cpu_memory_data  out  MEMORY_WIDTH  fetched word broadcast to all CPUs; equals mem_rdata
- host_wr_valid  in  1  host program write request, held until host_wr_ready
- host_wr_addr  in  MEMORY_ADDR_WIDTH  host write address
- host_wr_data  in  MEMORY_WIDTH  host write data
- host_wr_ready  out  1  registered grant pulse for host write
- mem_en  out  1  memory port enable, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  MEMORY_ADDR_WIDTH  memory address, registered
- mem_wdata  out  MEMORY_WIDTH  memory write data, registered
- mem_rdata  in  MEMORY_WIDTH  memory read data, valid the cycle after the access cycle (1-cycle RAM latency)

## Operation
- Eligible CPU set each cycle: req = cpu_memory_valid & ~cpu_memory_ready. A requester currently receiving its ready pulse is excluded, so it is never double-granted.
- Host eligibility: host_wr_valid & ~host_wr_ready.
- Priority: an eligible host beats all CPUs. Otherwise the winner is the first eligible CPU scanning rr_ptr, rr_ptr+1, … modulo N.
- On a CPU grant i:
  - Register cpu_memory_ready[i]=1, mem_en=1, mem_we=0, mem_addr=addr_i.
  - rr_ptr <= i+1, wrapping modulo N through natural CPU_ID_BITS overflow.
- On a host grant:
  - Register host_wr_ready=1, mem_en=1, mem_we=1, mem_addr/mem_wdata from the host port.
  - rr_ptr is unchanged.
- No grant: all ready outputs and mem_en/mem_we are 0. mem_addr/mem_wdata hold their last values.
- cpu_memory_data is a combinational wire from mem_rdata. Only the CPU that saw ready in the previous cycle samples it.
- There is no internal queue. Throughput is one access per cycle across distinct requesters. A single CPU can issue at most one access per 2 cycles, because it must drop and reassert valid.
- Host priority may starve CPUs while host_wr_valid is streamed. This is intended: program load happens while the CPUs are idle.

## Timing
- Reset values: cpu_memory_ready=0, host_wr_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rr_ptr=0.
- Cycle T: the request is visible (valid high, address stable). The arbiter decides.
- Cycle T+1: ready pulse high, and mem_en/mem_addr present to the RAM. The RAM samples at the end of T+1.
- Cycle T+2: mem_rdata, and therefore cpu_memory_data, holds the fetched word. The requester has dropped its valid.
- Request-to-data latency: 2 cycles when uncontended. Each losing requester waits 1 extra cycle per earlier grant.
- Simultaneous requests from all N CPUs with rr_ptr=0: grants land on consecutive cycles in order 0,1,…,N-1, with no bubbles.
- Host and CPU requests in the same cycle: the host is granted. The CPU grant follows the next cycle.
- Reset asserted in any cycle clears all pulses and the pointer at the next edge. A request being granted in that cycle is dropped. A CPU still holding valid is re-served after reset.
- A valid that deasserts before its grant (protocol violation) is simply not granted. The arbiter never emits a grant to a requester with valid low in the decision cycle.

## Test plan
- CPU 2 alone requests addr 0x1A5; RAM word 0x3_0062 at 0x1A5 -> cpu_memory_ready=4'b0100 one cycle later, mem_addr=0x1A5, mem_en=1, mem_we=0; next cycle cpu_memory_data=0x3_0062; rr_ptr becomes 3.
- All 4 CPUs request addrs 0x010,0x020,0x030,0x040 in the same cycle after reset -> ready pulses 0001,0010,0100,1000 on 4 consecutive cycles; mem_addr sequence 0x010,0x020,0x030,0x040; each CPU gets its own word 1 cycle after its pulse.
- Round-robin wrap: rr_ptr=3 and CPUs 0 and 3 request -> CPU 3 is granted first, then CPU 0; rr_ptr ends at 1.
- Host writes 0x2_0131 to 0x07F while CPU 1 requests -> host_wr_ready and mem_we=1 first; CPU 1 is granted next cycle. A CPU 1 read of 0x07F returns 0x2_0131.
- Reset asserted in the cycle CPU 0 is being decided -> no ready pulse and all outputs 0 after the edge; CPU 0 keeps valid and is granted 1 cycle after reset deasserts.
- CPU 1 drops and reasserts valid in alternate cycles for 20 requests with no contention -> exactly 20 ready pulses, never two in adjacent cycles, and no grant issued while valid is low.
